pipeline4: RTL and testbench

Fourth (memory/writeback) stage of the processor pipeline. It consumes each instruction that `pipeline3` retires: result `data`, memory `addr`, destination `reg_addr`, `ctrl`, and branch redirect. It performs LW/SW against data memory through a req/ack handshake and writes results to the register file. It forwards branch redirects to fetch and back-pressures `pipeline3` with `stall` while a memory access is in flight.

---
 rtl/pipeline4_pkg.sv | 50 +++++
 rtl/pipeline4_skid.sv | 44 ++++
 rtl/pipeline4.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pipeline4.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline4_pkg.sv
// pipeline4_pkg
// Shared definitions for the memory/writeback stage: default widths,
// opcode encodings, FSM state type and opcode classification helpers.
// No ports (package).

package pipeline4_pkg;

  // Default widths and limits.
  localparam int CTRL_WIDTH_DEF     = 4;
  localparam int PC_WIDTH_DEF       = 16;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int MEM_WIDTH_DEF      = 16;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int MEM_TIMEOUT_DEF    = 15;

  // Opcode encodings, in instruction-set order.
  localparam logic [3:0] OP_LW   = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_JR   = 4'd10;
  localparam logic [3:0] OP_JPC  = 4'd11;
  localparam logic [3:0] OP_BRFL = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  // Stage FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } p4_state_e;

  // True for instructions that go through data memory.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // True for instructions whose result is written to the register file.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/pipeline4_skid.sv
// pipe_skid1
// One-entry skid register: holds a single instruction word that arrived
// while the stage was stalled.
// Ports:
//   clk_i  : clock (rising edge)
//   rst_i  : synchronous active-high reset, empties the entry
//   load_i : capture data_i (only issued while empty)
//   pop_i  : release the held entry
//   data_i : instruction word to capture
//   full_o : entry valid
//   data_o : held instruction word

module pipe_skid1 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  // Entry valid flag and payload; a load takes precedence over a pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      dat_q <= data_i;
    end else if (pop_i) begin
      vld_q <= 1'b0;
    end
  end

  assign full_o = vld_q;
  assign data_o = dat_q;

endmodule

// File: rtl/pipeline4.sv
// pipeline4
// Memory/writeback stage. Executes LW/SW through a req/ack data-memory
// port with a timeout, writes results to the register file, forwards
// branch redirects and back-pressures the previous stage with stall.
// Ports:
//   clk_in, RST                    : clock, synchronous active-high reset
//   done, ctrl_in, data, addr,
//   reg_addr, pc_chg, pc_in        : instruction from the previous stage
//   stall                          : upstream must hold
//   mem_req/mem_we/mem_addr/
//   mem_wdata, mem_rdata, mem_ack  : data-memory handshake
//   wr_en/wr_addr/wr_data          : register-file write pulse
//   br_taken/br_target             : redirect pulse to fetch
//   mem_err                        : memory timeout pulse
//   ovf                            : instruction dropped (skid full) pulse
//   retired                        : completed-instruction counter

module pipeline4
  import pipeline4_pkg::*;
#(
  parameter int CTRL_WIDTH     = CTRL_WIDTH_DEF,
  parameter int PC_WIDTH       = PC_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_WIDTH      = MEM_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic                      done,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [MEM_WIDTH-1:0]      addr,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic                      pc_chg,
  input  logic [PC_WIDTH-1:0]       pc_in,
  output logic                      stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      br_taken,
  output logic [PC_WIDTH-1:0]       br_target,
  output logic                      mem_err,
  output logic                      ovf,
  output logic [15:0]               retired
);

  localparam int SKID_W = CTRL_WIDTH + DATA_WIDTH + MEM_WIDTH + REG_ADDR_WIDTH + 1 + PC_WIDTH;
  localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  // ---------------------------------------------------------------
  // Instruction selection: the skid entry is older than a live done,
  // so it is always consumed first.
  // ---------------------------------------------------------------
  logic                      skid_full_s;
  logic                      skid_load_s;
  logic                      skid_pop_s;
  logic [SKID_W-1:0]         skid_pkt_s;
  logic [SKID_W-1:0]         live_pkt_s;
  logic [SKID_W-1:0]         cur_pkt_s;
  logic [CTRL_WIDTH-1:0]     cur_ctrl_s;
  logic [DATA_WIDTH-1:0]     cur_data_s;
  logic [MEM_WIDTH-1:0]      cur_addr_s;
  logic [REG_ADDR_WIDTH-1:0] cur_rd_s;
  logic                      cur_pc_chg_s;
  logic [PC_WIDTH-1:0]       cur_pc_s;
  logic [3:0]                cur_op_s;
  logic                      take_s;
  logic                      live_taken_s;

  // Registered state.
  p4_state_e                 state_q, state_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      pend_lw_q, pend_lw_d;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
  // LW result waiting one cycle for the register-file write.
  logic                      wbp_q, wbp_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

  // Output registers.
  logic                      stall_q, stall_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      br_taken_q, br_taken_d;
  logic [PC_WIDTH-1:0]       br_target_q, br_target_d;
  logic                      mem_err_q, mem_err_d;
  logic                      ovf_q, ovf_d;
  logic [15:0]               retired_q, retired_d;

  assign live_pkt_s = {ctrl_in, data, addr, reg_addr, pc_chg, pc_in};
  assign cur_pkt_s  = skid_full_s ? skid_pkt_s : live_pkt_s;
  assign {cur_ctrl_s, cur_data_s, cur_addr_s, cur_rd_s, cur_pc_chg_s, cur_pc_s} = cur_pkt_s;
  assign cur_op_s   = 4'(cur_ctrl_s);

  // An instruction is accepted only in IDLE with no LW writeback pending,
  // so the LW write and a following ALU write never share a cycle.
  assign take_s       = (state_q == ST_IDLE) && !wbp_q && (skid_full_s || done);
  assign live_taken_s = take_s && !skid_full_s;
  assign skid_pop_s   = take_s && skid_full_s;
  assign skid_load_s  = done && !live_taken_s && !skid_full_s;

  pipe_skid1 #(
    .W (SKID_W)
  ) u_skid (
    .clk_i  (clk_in),
    .rst_i  (RST),
    .load_i (skid_load_s),
    .pop_i  (skid_pop_s),
    .data_i (live_pkt_s),
    .full_o (skid_full_s),
    .data_o (skid_pkt_s)
  );

  // Next-state and next-output logic for the stage FSM.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    pend_lw_d   = pend_lw_q;
    pend_rd_d   = pend_rd_q;
    wbp_d       = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    mem_err_d   = 1'b0;
    retired_d   = retired_q;
    // A full skid cannot take the done of this cycle, even while draining.
    ovf_d       = done && !live_taken_s && skid_full_s;

    // Deferred LW writeback, one cycle after the ack.
    if (wbp_q) begin
      retired_d = retired_q + 16'd1;
      if (wb_addr_q != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wb_addr_q;
        wr_data_d = wb_data_q;
      end else begin
        wr_en_d = 1'b0;
      end
    end else begin
      wbp_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          if (cur_pc_chg_s) begin
            br_taken_d  = 1'b1;
            br_target_d = cur_pc_s;
          end else begin
            br_taken_d = 1'b0;
          end
          if (is_mem_op(cur_op_s)) begin
            state_d     = ST_MEM;
            tmo_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = (cur_op_s == OP_SW);
            mem_addr_d  = cur_addr_s;
            mem_wdata_d = (cur_op_s == OP_SW) ? cur_data_s : '0;
            pend_lw_d   = (cur_op_s == OP_LW);
            pend_rd_d   = cur_rd_s;
          end else begin
            retired_d = retired_q + 16'd1;
            if (is_alu_op(cur_op_s) && (cur_rd_s != '0)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = cur_rd_s;
              wr_data_d = cur_data_s;
            end else begin
              wr_en_d = 1'b0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (mem_ack) begin
          state_d   = ST_IDLE;
          tmo_d     = '0;
          mem_req_d = 1'b0;
          if (pend_lw_q) begin
            wbp_d     = 1'b1;
            wb_addr_d = pend_rd_q;
            wb_data_d = mem_rdata;
          end else begin
            retired_d = retired_q + 16'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          tmo_d     = '0;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Stall holds while a memory access is outstanding or the skid is occupied.
    stall_d = (state_d == ST_MEM) || skid_load_s || (skid_full_s && !skid_pop_s);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      pend_lw_q   <= 1'b0;
      pend_rd_q   <= '0;
      wbp_q       <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      stall_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      mem_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      retired_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      pend_lw_q   <= pend_lw_d;
      pend_rd_q   <= pend_rd_d;
      wbp_q       <= wbp_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      stall_q     <= stall_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      mem_err_q   <= mem_err_d;
      ovf_q       <= ovf_d;
      retired_q   <= retired_d;
    end
  end

  assign stall     = stall_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign mem_err   = mem_err_q;
  assign ovf       = ovf_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_pipeline4.sv
module tb_pipeline4;
  import pipeline4_pkg::*;

  logic        clk_in = 1'b0;
  logic        RST = 1'b1;
  logic        done = 1'b0;
  logic [3:0]  ctrl_in = 4'd0;
  logic [31:0] data = 32'd0;
  logic [15:0] addr = 16'd0;
  logic [4:0]  reg_addr = 5'd0;
  logic        pc_chg = 1'b0;
  logic [15:0] pc_in = 16'd0;
  logic        stall, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        br_taken;
  logic [15:0] br_target;
  logic        mem_err, ovf;
  logic [15:0] retired;

  pipeline4 dut (
    .clk_in(clk_in), .RST(RST), .done(done), .ctrl_in(ctrl_in), .data(data),
    .addr(addr), .reg_addr(reg_addr), .pc_chg(pc_chg), .pc_in(pc_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .br_taken(br_taken), .br_target(br_target), .mem_err(mem_err),
    .ovf(ovf), .retired(retired)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  // Observed event streams, collected away from the active edge.
  logic [36:0] act_wr[$];
  logic [15:0] act_br[$];
  int          n_err = 0;
  int          n_ovf = 0;

  always @(negedge clk_in) begin
    if (wr_en === 1'b1) act_wr.push_back({wr_addr, wr_data});
    if (br_taken === 1'b1) act_br.push_back(br_target);
    if (mem_err === 1'b1) n_err++;
    if (ovf === 1'b1) n_ovf++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One-cycle done pulse carrying an instruction.
  task automatic send(input logic [3:0] op, input logic [31:0] d, input logic [15:0] a,
                      input logic [4:0] rd, input logic pcv, input logic [15:0] pc);
    ctrl_in = op; data = d; addr = a; reg_addr = rd; pc_chg = pcv; pc_in = pc;
    done = 1'b1;
    tick();
    done = 1'b0;
    pc_chg = 1'b0;
  endtask

  // Reference model for the random phase: expected event streams.
  logic [36:0] exp_wr[$];
  logic [15:0] exp_br[$];
  int          exp_err;
  logic [15:0] exp_ret;

  initial begin
    int cnt;
    int nwr;
    logic [3:0]  op;
    logic [31:0] dv, rdv;
    logic [15:0] av, pcv_val;
    logic [4:0]  rd;
    logic        pcv;
    logic        is_write_op;

    // ---------------- reset ----------------
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_retired", retired, 0);
    check("rst_wr_data", wr_data, 0);

    // ---------------- ADD ----------------
    send(OP_ADD, 32'd135, 16'd0, 5'd10, 1'b0, 16'd0);
    check("add_wr_en", wr_en, 1);
    check("add_wr_addr", wr_addr, 10);
    check("add_wr_data", wr_data, 135);
    check("add_retired", retired, 1);
    check("add_stall", stall, 0);
    tick();
    check("add_wr_en_pulse", wr_en, 0);

    // ---------------- LW with ack after 3 stall cycles ----------------
    send(OP_LW, 32'd0, 16'd42, 5'd5, 1'b0, 16'd0);
    check("lw_mem_req", mem_req, 1);
    check("lw_mem_we", mem_we, 0);
    check("lw_mem_addr", mem_addr, 42);
    check("lw_stall1", stall, 1);
    tick();
    check("lw_stall2", stall, 1);
    tick();
    check("lw_stall3", stall, 1);
    mem_rdata = -32'sd7; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lw_req_drop", mem_req, 0);
    check("lw_stall_drop", stall, 0);
    check("lw_no_early_wr", wr_en, 0);
    tick();
    check("lw_wr_en", wr_en, 1);
    check("lw_wr_addr", wr_addr, 5);
    check("lw_wr_data", wr_data, 32'hFFFF_FFF9);
    check("lw_retired", retired, 2);
    tick();

    // ---------------- SW timeout ----------------
    send(OP_SW, 32'd65, 16'd50, 5'd0, 1'b0, 16'd0);
    check("sw_mem_we", mem_we, 1);
    check("sw_mem_wdata", mem_wdata, 65);
    check("sw_mem_addr", mem_addr, 50);
    nwr = act_wr.size();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("tmo_req_cycles", cnt, 15);
    check("tmo_mem_err", mem_err, 1);
    check("tmo_stall", stall, 0);
    check("tmo_retired", retired, 2);
    tick();
    check("tmo_err_pulse", mem_err, 0);
    check("tmo_no_write", act_wr.size(), nwr);

    // ---------------- LW + SUB in skid + dropped third ----------------
    send(OP_LW, 32'd0, 16'd7, 5'd3, 1'b0, 16'd0);
    send(OP_SUB, 32'd125, 16'd0, 5'd20, 1'b0, 16'd0);
    check("skid_no_ovf", ovf, 0);
    send(OP_ADD, 32'd9, 16'd0, 5'd9, 1'b0, 16'd0);
    check("skid_ovf", ovf, 1);
    mem_rdata = 32'd1234; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("skid_ovf_pulse", ovf, 0);
    check("skid_req_drop", mem_req, 0);
    check("skid_stall_held", stall, 1);
    tick();
    check("skid_lw_wr_en", wr_en, 1);
    check("skid_lw_wr_addr", wr_addr, 3);
    check("skid_lw_wr_data", wr_data, 1234);
    tick();
    check("skid_sub_wr_en", wr_en, 1);
    check("skid_sub_wr_addr", wr_addr, 20);
    check("skid_sub_wr_data", wr_data, 125);
    check("skid_stall_free", stall, 0);
    check("skid_retired", retired, 4);
    tick();
    check("skid_no_third", wr_en, 0);

    // ---------------- BRFL redirect ----------------
    send(OP_BRFL, 32'd77, 16'd0, 5'd4, 1'b1, 16'd11531);
    check("br_taken", br_taken, 1);
    check("br_target", br_target, 11531);
    check("br_no_write", wr_en, 0);
    check("br_retired", retired, 5);
    tick();
    check("br_pulse", br_taken, 0);

    // ---------------- ack on the timeout edge ----------------
    send(OP_SW, 32'd3, 16'd77, 5'd0, 1'b0, 16'd0);
    repeat (14) tick();
    check("race_req_held", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("race_no_err", mem_err, 0);
    check("race_req_drop", mem_req, 0);
    check("race_retired", retired, 6);
    tick();
    check("race_no_err_later", mem_err, 0);

    // ---------------- RST during LW wait ----------------
    send(OP_LW, 32'd0, 16'd99, 5'd6, 1'b0, 16'd0);
    send(OP_SUB, 32'd55, 16'd0, 5'd8, 1'b0, 16'd0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mrst_mem_req", mem_req, 0);
    check("mrst_stall", stall, 0);
    check("mrst_retired", retired, 0);
    check("mrst_mem_err", mem_err, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_wr_en", wr_en, 0);
    nwr = act_wr.size();
    mem_rdata = 32'd4321; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("mrst_ack_ignored", mem_req, 0);
    repeat (3) tick();
    check("mrst_no_write", act_wr.size(), nwr);
    check("mrst_retired_after", retired, 0);
    check("mrst_stall_after", stall, 0);

    // ---------------- randomized phase ----------------
    act_wr.delete(); act_br.delete(); n_err = 0; n_ovf = 0;
    exp_wr.delete(); exp_br.delete(); exp_err = 0; exp_ret = 16'd0;
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      dv = $urandom();
      av = 16'($urandom());
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pcv = ($urandom_range(0, 2) == 0);
      pcv_val = 16'($urandom());
      is_write_op = op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_CMP};
      if (pcv) exp_br.push_back(pcv_val);
      send(op, dv, av, rd, pcv, pcv_val);
      if (op == OP_LW || op == OP_SW) begin
        check("rnd_mem_req", mem_req, 1);
        check("rnd_mem_addr", mem_addr, av);
        check("rnd_mem_we", mem_we, (op == OP_SW));
        if ($urandom_range(0, 7) == 0) begin
          cnt = 0;
          while (mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
          end
          check("rnd_timeout_err", mem_err, 1);
          exp_err++;
        end else begin
          repeat ($urandom_range(0, 4)) tick();
          rdv = $urandom();
          mem_rdata = rdv; mem_ack = 1'b1;
          tick();
          mem_ack = 1'b0;
          check("rnd_ack_req_drop", mem_req, 0);
          if (op == OP_LW && rd != 5'd0) exp_wr.push_back({rd, rdv});
          exp_ret++;
          tick();
        end
      end else begin
        if (is_write_op && rd != 5'd0) exp_wr.push_back({rd, dv});
        exp_ret++;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    tick(); tick();
    check("rnd_retired", retired, exp_ret);
    check("rnd_n_err", n_err, exp_err);
    check("rnd_n_ovf", n_ovf, 0);
    check("rnd_n_wr", act_wr.size(), exp_wr.size());
    check("rnd_n_br", act_br.size(), exp_br.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      check("rnd_wr_event", act_wr[i], exp_wr[i]);
    for (int i = 0; i < exp_br.size() && i < act_br.size(); i++)
      check("rnd_br_event", act_br[i], exp_br[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
